reg_to_obi_master: RTL

REG_TO_OBI_MASTER -- requirements
Module: reg_to_obi_master

---
 rtl/reg_to_obi_master.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_to_obi_master.sv
// Bridges a simple valid/ready register bus onto an OBI initiator port.
// One transaction in flight; a DATA-phase timeout answers with an error and drops the late rvalid.
module reg_to_obi_master #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // register-bus target side
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [31:0] reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [3:0]  reg_wstrb_i,
    output logic        reg_ready_o,
    output logic [31:0] reg_rdata_o,
    output logic        reg_error_o,
    // OBI initiator side
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    localparam logic [31:0] TimeoutData = 32'hBADC_AB1E;
    // count_reg holds the number of DATA cycles already elapsed, so the last
    // permitted cycle is the one where it equals TimeoutCycles-1.
    localparam logic [15:0] CountLast   = 16'(TimeoutCycles - 1);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic        stale_reg;
    logic [3:0]  be_next;

    // Reads always fetch the full word; writes use the caller's strobes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign be_next[gi] = reg_write_i ? reg_wstrb_i[gi] : 1'b1;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            stale_reg   <= 1'b0;
            reg_ready_o <= 1'b0;
            reg_error_o <= 1'b0;
            reg_rdata_o <= '0;
            obi_req_o   <= 1'b0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_addr_o  <= '0;
            obi_wdata_o <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    reg_ready_o <= 1'b0;
                    if (stale_reg) begin
                        // Waiting for the orphaned response of a timed-out access.
                        if (obi_rvalid_i) begin
                            stale_reg <= 1'b0;
                        end
                    end else if (reg_valid_i) begin
                        obi_addr_o  <= reg_addr_i;
                        obi_we_o    <= reg_write_i;
                        obi_wdata_o <= reg_wdata_i;
                        obi_be_o    <= be_next;
                        obi_req_o   <= 1'b1;
                        state_reg   <= ADDR;
                    end
                end
                ADDR: begin
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        count_reg <= '0;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (obi_rvalid_i) begin
                        reg_rdata_o <= obi_we_o ? 32'h0 : obi_rdata_i;
                        reg_error_o <= 1'b0;
                        reg_ready_o <= 1'b1;
                        state_reg   <= RESP;
                    end else if (count_reg == CountLast) begin
                        reg_rdata_o <= TimeoutData;
                        reg_error_o <= 1'b1;
                        reg_ready_o <= 1'b1;
                        stale_reg   <= 1'b1;
                        state_reg   <= RESP;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                RESP: begin
                    reg_ready_o <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
